// File: rtl/seq_detect_sched_if.sv
// rtl/seq_detect_sched_if.sv - requester/response handshake bundle for seq_detect_sched
// Purpose: groups the two word requesters and the result channel.
// Ports:
//   req0_*/req1_* : valid/data in, ready out (word accepted when valid && ready)
//   rsp_*         : valid/id/count out, ready in
//   slave modport : scheduler side; master modport : producer/consumer side
interface seq_detect_sched_if #(
   parameter int WORD_W = 8
);
   logic              req0_valid;
   logic [WORD_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [WORD_W-1:0] req1_data;
   logic              req1_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [3:0]        rsp_count;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
   );
endinterface

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin scheduler sharing one serial overlapping pattern detector
// Purpose: accepts 8-bit words from two requesters, shifts the granted word
//   MSB-first through a programmable Mealy detector and returns the match
//   count tagged with the requester id.
// Ports:
//   clk, sync_reset : clock, synchronous active-high reset
//   cfg_we, cfg_pattern : pattern write (honoured in IDLE only)
//   bus         : requester/response handshakes (slave modport)
//   match_pulse : high in the SHIFT cycle whose bit completes a match
//   busy        : high in SHIFT and DONE
//   state       : 0 IDLE, 1 SHIFT, 2 DONE
module seq_detect_sched #(
   parameter int                 WORD_W        = 8,
   parameter int                 PAT_LEN       = 4,
   parameter logic [PAT_LEN-1:0] RESET_PATTERN = 4'b1011
) (
   input  logic               clk,
   input  logic               sync_reset,
   input  logic               cfg_we,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   seq_detect_sched_if.slave  bus,
   output logic               match_pulse,
   output logic               busy,
   output logic [1:0]         state
);
   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             cur_state;
   state_t             nxt_state;

   logic [WORD_W-1:0]  shreg;
   logic [PAT_LEN-2:0] hist;
   logic [CNT_W-1:0]   bit_cnt;
   logic [3:0]         count;
   logic [PAT_LEN-1:0] pattern;
   logic               last_grant;
   logic               rsp_id_q;

   logic               grant;
   logic               grant_valid;
   logic               accept;
   logic               shift_bit;
   logic [PAT_LEN-1:0] window;
   logic               window_hit;
   logic               last_bit;

   // Round-robin: on a tie the requester not served last wins; reset
   // leaves last_grant at 1 so req0 takes the first tie.
   always_comb begin
      grant_valid = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = ~last_grant;
      end else begin
         grant = bus.req1_valid;
      end
   end

   assign accept         = (cur_state == ST_IDLE) && grant_valid;
   assign bus.req0_ready = (cur_state == ST_IDLE) && bus.req0_valid && !grant;
   assign bus.req1_ready = (cur_state == ST_IDLE) && bus.req1_valid && grant;

   // The window includes the bit being shifted now, so a match is flagged in
   // the same cycle (Mealy). Bits from before this word never qualify because
   // the history is cleared on accept and bit_cnt gates the first PAT_LEN-1.
   assign shift_bit  = shreg[WORD_W-1];
   assign window     = {hist, shift_bit};
   assign window_hit = (window == pattern) && (bit_cnt >= MIN_BITS);
   assign last_bit   = (bit_cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         cur_state <= ST_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state   = cur_state;
      match_pulse = 1'b0;
      case (cur_state)
         ST_IDLE: begin
            if (accept) begin
               nxt_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            match_pulse = window_hit;
            if (last_bit) begin
               nxt_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.rsp_ready) begin
               nxt_state = ST_IDLE;
            end
         end
         default: begin
            nxt_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         pattern    <= RESET_PATTERN;
         last_grant <= 1'b1;
         shreg      <= '0;
         hist       <= '0;
         bit_cnt    <= '0;
         count      <= '0;
         rsp_id_q   <= 1'b0;
      end else begin
         // Pattern only matters from the next SHIFT cycle on, so a write in
         // the accept cycle is naturally seen by the accepted word.
         if ((cur_state == ST_IDLE) && cfg_we) begin
            pattern <= cfg_pattern;
         end
         if (accept) begin
            shreg      <= grant ? bus.req1_data : bus.req0_data;
            hist       <= '0;
            bit_cnt    <= '0;
            count      <= '0;
            rsp_id_q   <= grant;
            last_grant <= grant;
         end else if (cur_state == ST_SHIFT) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            hist    <= window[PAT_LEN-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (window_hit) begin
               count <= count + 4'd1;
            end
         end
      end
   end

   assign bus.rsp_valid = (cur_state == ST_DONE);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_count = count;
   assign busy          = (cur_state != ST_IDLE);
   assign state         = cur_state;
endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - directed scoreboard bench for seq_detect_sched
module tb_seq_detect_sched;
   logic       clk = 1'b0;
   logic       sync_reset = 1'b1;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_pattern = 4'b0000;
   logic       match_pulse;
   logic       busy;
   logic [1:0] state;

   seq_detect_sched_if #(.WORD_W(8)) bus ();

   seq_detect_sched #(
      .WORD_W(8),
      .PAT_LEN(4),
      .RESET_PATTERN(4'b1011)
   ) dut (
      .clk(clk),
      .sync_reset(sync_reset),
      .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern),
      .bus(bus),
      .match_pulse(match_pulse),
      .busy(busy),
      .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       id;
      logic [3:0] count;
      logic [7:0] mask;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] model_pat = 4'b1011;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: slide a 4-bit window over the word MSB-first; the window
   // ending at bit position i (0 = first shifted) is w >> (7-i).
   function automatic exp_t model(input logic id, input logic [7:0] w, input logic [3:0] pat);
      exp_t e;
      logic [7:0] sh;
      e.id = id;
      e.count = 4'd0;
      e.mask = 8'd0;
      for (int i = 3; i < 8; i++) begin
         sh = w >> (7 - i);
         if (sh[3:0] == pat) begin
            e.count = e.count + 4'd1;
            e.mask[7-i] = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic wait_ready(input logic id);
      int n = 0;
      #1;
      while (((id == 1'b0) ? bus.req0_ready : bus.req1_ready) !== 1'b1 && n < 30) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk($sformatf("ready_req%0d", id), 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
   endtask

   task automatic collect(input int cfg_at, input logic [3:0] cfg_val, input bit keep,
                          output logic [7:0] mask);
      mask = 8'd0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!keep) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
         end
         cfg_we = (i == cfg_at);
         if (i == cfg_at) cfg_pattern = cfg_val;
         #1;
         chk($sformatf("shift_state_%0d", i), 32'(state), 32'd1);
         mask[7-i] = match_pulse;
      end
      @(negedge clk);
      cfg_we = 1'b0;
      #1;
   endtask

   task automatic check_rsp(input int hold, input logic [7:0] mask);
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("done_state", 32'(state), 32'd2);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
      chk("rsp_count", 32'(bus.rsp_count), 32'(e.count));
      chk("match_mask", 32'(mask), 32'(e.mask));
      bus.rsp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         #1;
         chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_id", 32'(bus.rsp_id), 32'(e.id));
         chk("hold_count", 32'(bus.rsp_count), 32'(e.count));
         chk("hold_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      chk("back_idle", 32'(state), 32'd0);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
   endtask

   // cfg_at = -2 writes cfg_val in the accept cycle; 0..7 writes during SHIFT.
   task automatic do_word(input logic id, input logic [7:0] w, input int hold,
                          input int cfg_at, input logic [3:0] cfg_val);
      logic [7:0] mask;
      @(negedge clk);
      if (id) begin
         bus.req1_valid = 1'b1;
         bus.req1_data  = w;
      end else begin
         bus.req0_valid = 1'b1;
         bus.req0_data  = w;
      end
      if (cfg_at == -2) begin
         cfg_we      = 1'b1;
         cfg_pattern = cfg_val;
         model_pat   = cfg_val;
      end
      sb.push_back(model(id, w, model_pat));
      wait_ready(id);
      collect(cfg_at, cfg_val, 1'b0, mask);
      check_rsp(hold, mask);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] mask;
      bus.req0_valid = 1'b0;
      bus.req0_data  = 8'h00;
      bus.req1_valid = 1'b0;
      bus.req1_data  = 8'h00;
      bus.rsp_ready  = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_count", 32'(bus.rsp_count), 32'd0);
      chk("rst_match", 32'(match_pulse), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      bus.req0_valid = 1'b1;
      #1;
      chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
      bus.req0_valid = 1'b0;
      sync_reset = 1'b0;

      // Reset pattern 1011 on 1011_0110: matches on 4th and 7th shift
      do_word(1'b0, 8'b1011_0110, 0, -1, 4'd0);

      // Pattern 1111 written in a standalone IDLE cycle
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_pattern = 4'b1111;
      model_pat = 4'b1111;
      @(negedge clk);
      cfg_we = 1'b0;
      do_word(1'b0, 8'hFF, 0, -1, 4'd0);
      do_word(1'b1, 8'h00, 0, -1, 4'd0);

      // Writes during SHIFT are ignored for this and the next word
      do_word(1'b0, 8'hFF, 0, 2, 4'b0000);
      do_word(1'b0, 8'h1F, 0, 5, 4'b0000);
      // Write in the accept cycle applies to the accepted word
      do_word(1'b0, 8'b1011_0110, 0, -2, 4'b1011);

      // Both requesters valid from reset: grants alternate 0,1,0
      @(negedge clk);
      sync_reset = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'b1011_1011;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'b0101_1000;
      @(negedge clk);
      sync_reset = 1'b0;
      model_pat = 4'b1011;
      sb.push_back(model(1'b0, 8'b1011_1011, model_pat));
      sb.push_back(model(1'b1, 8'b0101_1000, model_pat));
      sb.push_back(model(1'b0, 8'b1011_1011, model_pat));
      #1;
      chk("tie_first_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
      wait_ready(1'b0);
      collect(-1, 4'd0, 1'b1, mask);
      check_rsp(0, mask);
      chk("tie_second_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
      wait_ready(1'b1);
      collect(-1, 4'd0, 1'b1, mask);
      check_rsp(5, mask);
      chk("tie_third_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
      wait_ready(1'b0);
      collect(-1, 4'd0, 1'b0, mask);
      check_rsp(0, mask);

      // Reset mid-SHIFT discards the word and restores pattern 1011
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_pattern = 4'b1111;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'hFF;
      sb.push_back(model(1'b0, 8'hFF, 4'b1111));
      wait_ready(1'b0);
      @(negedge clk);
      cfg_we = 1'b0;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      sync_reset = 1'b1;
      @(negedge clk);
      sync_reset = 1'b0;
      #1;
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_count", 32'(bus.rsp_count), 32'd0);
      sb.delete();
      model_pat = 4'b1011;
      do_word(1'b0, 8'b1011_0110, 0, -1, 4'd0);
      do_word(1'b1, 8'b0101_1011, 0, -1, 4'd0);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
